vga_timing_gen: RTL and testbench



---
 rtl/vga_timing_pkg.sv | 22 ++
 rtl/vga_timing_gen_pixel_strobe_gen.sv | 33 +++
 rtl/vga_timing_gen.sv | 116 +++++++++++
 tb/tb_vga_timing_gen.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster timing constants and sync-window decode for the VGA timing generator.
package vga_timing_pkg;

    localparam int unsigned vga_width    = 640;
    localparam int unsigned vga_height   = 480;
    localparam int unsigned vga_h_front  = 16;
    localparam int unsigned vga_h_sync   = 96;
    localparam int unsigned vga_h_back   = 48;
    localparam int unsigned vga_v_front  = 10;
    localparam int unsigned vga_v_sync   = 2;
    localparam int unsigned vga_v_back   = 33;
    localparam int unsigned vga_h_total  = vga_width + vga_h_front + vga_h_sync + vga_h_back;
    localparam int unsigned vga_v_total  = vga_height + vga_v_front + vga_v_sync + vga_v_back;

    // True when cnt lies in the half-open window [start, start + len).
    function automatic logic in_window(input int unsigned cnt,
                                       input int unsigned start,
                                       input int unsigned len);
        return (cnt >= start) && (cnt < start + len);
    endfunction

endpackage

// File: rtl/vga_timing_gen_pixel_strobe_gen.sv
// Clock-enable divider: registered one-clk strobe every div system clocks.
module pixel_strobe_gen #(
    parameter int unsigned div = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic pixel_en
);

    localparam int unsigned     w_div    = (div > 1) ? $clog2(div) : 1;
    localparam logic [w_div-1:0] div_last = w_div'(div - 1);

    logic [w_div-1:0] div_q, div_d;
    logic             pixel_en_q, pixel_en_d;

    always_comb begin
        div_d      = (div_q == div_last) ? '0 : div_q + w_div'(1);
        pixel_en_d = (div_d == div_last);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q      <= '0;
            pixel_en_q <= 1'b0;
        end else begin
            div_q      <= div_d;
            pixel_en_q <= pixel_en_d;
        end
    end

    assign pixel_en = pixel_en_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel strobe, x/y position, display qualifier, sync pulses and frame start.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned clk_mhz         = 50,
    parameter int unsigned pixel_mhz       = 25,
    parameter int unsigned screen_width    = vga_width,
    parameter int unsigned screen_height   = vga_height,
    parameter int unsigned h_front         = vga_h_front,
    parameter int unsigned h_sync          = vga_h_sync,
    parameter int unsigned h_back          = vga_h_back,
    parameter int unsigned v_front         = vga_v_front,
    parameter int unsigned v_sync          = vga_v_sync,
    parameter int unsigned v_back          = vga_v_back,
    parameter bit          sync_active_low = 1'b1,
    parameter int unsigned w_x             = $clog2(screen_width),
    parameter int unsigned w_y             = $clog2(screen_height)
) (
    input  logic           clk,
    input  logic           rst_n,
    output logic           pixel_en,
    output logic           hsync,
    output logic           vsync,
    output logic           display_on,
    output logic [w_x-1:0] x,
    output logic [w_y-1:0] y,
    output logic           frame_start
);

    localparam int unsigned div     = clk_mhz / pixel_mhz;
    localparam int unsigned h_total = screen_width + h_front + h_sync + h_back;
    localparam int unsigned v_total = screen_height + v_front + v_sync + v_back;
    localparam int unsigned w_h     = $clog2(h_total);
    localparam int unsigned w_v     = $clog2(v_total);

    localparam logic [w_h-1:0] h_last = w_h'(h_total - 1);
    localparam logic [w_v-1:0] v_last = w_v'(v_total - 1);
    localparam logic [w_h-1:0] h_vis  = w_h'(screen_width);
    localparam logic [w_v-1:0] v_vis  = w_v'(screen_height);

    if ((clk_mhz < pixel_mhz) || (clk_mhz % pixel_mhz != 0)) begin : g_bad_clk
        $error("vga_timing_gen: clk_mhz must be a non-zero multiple of pixel_mhz");
    end

    logic pixel_strobe;

    pixel_strobe_gen #(
        .div (div)
    ) u_pixel_strobe (
        .clk      (clk),
        .rst_n    (rst_n),
        .pixel_en (pixel_strobe)
    );

    logic [w_h-1:0] hcnt_q, hcnt_d;
    logic [w_v-1:0] vcnt_q, vcnt_d;
    logic           display_on_q, display_on_d;
    logic           hsync_q, hsync_d;
    logic           vsync_q, vsync_d;
    logic [w_x-1:0] x_q, x_d;
    logic [w_y-1:0] y_q, y_d;
    logic           frame_start_q, frame_start_d;

    // Outputs decode the next-state counters so they switch on the same edge as the raster.
    always_comb begin
        hcnt_d = hcnt_q;
        vcnt_d = vcnt_q;
        if (pixel_strobe) begin
            if (hcnt_q == h_last) begin
                hcnt_d = '0;
                vcnt_d = (vcnt_q == v_last) ? '0 : vcnt_q + w_v'(1);
            end else begin
                hcnt_d = hcnt_q + w_h'(1);
            end
        end

        display_on_d  = (hcnt_d < h_vis) && (vcnt_d < v_vis);
        hsync_d       = in_window(32'(hcnt_d), screen_width + h_front, h_sync) ^ sync_active_low;
        vsync_d       = in_window(32'(vcnt_d), screen_height + v_front, v_sync) ^ sync_active_low;
        x_d           = display_on_d ? w_x'(hcnt_d) : '0;
        y_d           = display_on_d ? w_y'(vcnt_d) : '0;
        frame_start_d = pixel_strobe && (hcnt_d == '0) && (vcnt_d == '0);
    end

    // Reset parks the raster on the last position so the first strobe lands on (0, 0).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hcnt_q        <= h_last;
            vcnt_q        <= v_last;
            display_on_q  <= 1'b0;
            hsync_q       <= sync_active_low;
            vsync_q       <= sync_active_low;
            x_q           <= '0;
            y_q           <= '0;
            frame_start_q <= 1'b0;
        end else begin
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            display_on_q  <= display_on_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            x_q           <= x_d;
            y_q           <= y_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign pixel_en    = pixel_strobe;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign display_on  = display_on_q;
    assign x           = x_q;
    assign y           = y_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three timing configurations checked cycle-by-cycle against a raster model.
module tb_vga_timing_gen;

    typedef struct packed {
        logic        pe;
        logic        hs;
        logic        vs;
        logic        de;
        logic        fs;
        logic [15:0] x;
        logic [15:0] y;
    } obs_t;

    typedef struct {
        int unsigned div;
        int unsigned wid, hei;
        int unsigned hf, hsw, hb;
        int unsigned vf, vsw, vb;
        bit          low;
    } cfg_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n [3];
    obs_t        act   [3];
    obs_t        sb_q  [3][$];
    int unsigned checks = 0;
    int unsigned errors = 0;

    function automatic cfg_t cfg_of(input int i);
        cfg_t c;
        case (i)
            0:       c = '{2, 640, 480, 16, 96, 48, 10, 2, 33, 1'b1};
            1:       c = '{1, 8, 4, 2, 3, 1, 1, 2, 1, 1'b0};
            default: c = '{3, 10, 6, 1, 2, 3, 2, 1, 2, 1'b1};
        endcase
        return c;
    endfunction

    // Number of raster advances after t clock edges out of reset.
    function automatic int unsigned advances(input int unsigned div, input int unsigned t);
        if (t == 0) return 0;
        if (div == 1) return t - 1;
        return t / div;
    endfunction

    // Expected outputs t edges after reset release (t = 0: in reset).
    function automatic obs_t model(input cfg_t c, input int unsigned t);
        obs_t        o;
        int unsigned htot, vtot, n, np, pos, h, v;
        htot = c.wid + c.hf + c.hsw + c.hb;
        vtot = c.hei + c.vf + c.vsw + c.vb;
        o    = '0;
        o.hs = c.low;
        o.vs = c.low;
        if (t == 0) return o;
        o.pe = ((t % c.div) == c.div - 1);
        n    = advances(c.div, t);
        np   = advances(c.div, t - 1);
        if (n == 0) return o;
        pos  = (n - 1) % (htot * vtot);
        h    = pos % htot;
        v    = pos / htot;
        o.de = (h < c.wid) && (v < c.hei);
        o.hs = ((h >= c.wid + c.hf) && (h < c.wid + c.hf + c.hsw)) ^ c.low;
        o.vs = ((v >= c.hei + c.vf) && (v < c.hei + c.vf + c.vsw)) ^ c.low;
        o.fs = (n != np) && (pos == 0);
        if (o.de) begin
            o.x = 16'(h);
            o.y = 16'(v);
        end
        return o;
    endfunction

    logic       pe0, hs0, vs0, de0, fs0;
    logic [9:0] x0;
    logic [8:0] y0;
    logic       pe1, hs1, vs1, de1, fs1;
    logic [2:0] x1;
    logic [1:0] y1;
    logic       pe2, hs2, vs2, de2, fs2;
    logic [3:0] x2;
    logic [2:0] y2;

    vga_timing_gen u_def (
        .clk(clk), .rst_n(rst_n[0]), .pixel_en(pe0), .hsync(hs0), .vsync(vs0),
        .display_on(de0), .x(x0), .y(y0), .frame_start(fs0)
    );

    vga_timing_gen #(
        .clk_mhz(25), .pixel_mhz(25), .screen_width(8), .screen_height(4),
        .h_front(2), .h_sync(3), .h_back(1), .v_front(1), .v_sync(2), .v_back(1),
        .sync_active_low(1'b0)
    ) u_one (
        .clk(clk), .rst_n(rst_n[1]), .pixel_en(pe1), .hsync(hs1), .vsync(vs1),
        .display_on(de1), .x(x1), .y(y1), .frame_start(fs1)
    );

    vga_timing_gen #(
        .clk_mhz(75), .pixel_mhz(25), .screen_width(10), .screen_height(6),
        .h_front(1), .h_sync(2), .h_back(3), .v_front(2), .v_sync(1), .v_back(2),
        .sync_active_low(1'b1)
    ) u_tri (
        .clk(clk), .rst_n(rst_n[2]), .pixel_en(pe2), .hsync(hs2), .vsync(vs2),
        .display_on(de2), .x(x2), .y(y2), .frame_start(fs2)
    );

    assign act[0] = {pe0, hs0, vs0, de0, fs0, 16'(x0), 16'(y0)};
    assign act[1] = {pe1, hs1, vs1, de1, fs1, 16'(x1), 16'(y1)};
    assign act[2] = {pe2, hs2, vs2, de2, fs2, 16'(x2), 16'(y2)};

    // Scoreboard producer: expected outputs after every edge.
    initial begin
        int unsigned t [3];
        t = '{0, 0, 0};
        forever begin
            @(posedge clk);
            for (int i = 0; i < 3; i++) begin
                if (!rst_n[i]) t[i] = 0;
                else           t[i] = t[i] + 1;
                sb_q[i].push_back(model(cfg_of(i), t[i]));
            end
        end
    end

    // Scoreboard consumer: compares the presented raster outputs away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                obs_t e;
                if (sb_q[i].size() != 0) begin
                    e = sb_q[i].pop_front();
                    checks++;
                    if (e !== act[i]) begin
                        errors++;
                        $display("FAIL raster%0d @%0t got pe=%b hs=%b vs=%b de=%b fs=%b x=%0d y=%0d want pe=%b hs=%b vs=%b de=%b fs=%b x=%0d y=%0d",
                                 i, $time, act[i].pe, act[i].hs, act[i].vs, act[i].de, act[i].fs,
                                 act[i].x, act[i].y, e.pe, e.hs, e.vs, e.de, e.fs, e.x, e.y);
                    end
                end
            end
        end
    end

    // Default-timing hsync pulse width and line period.
    initial begin
        int unsigned low_cnt = 0;
        int unsigned cyc = 0;
        int unsigned last_fall = 0;
        int unsigned falls = 0;
        logic        prev = 1'b1;
        forever begin
            @(negedge clk);
            cyc++;
            if (prev === 1'b1 && hs0 === 1'b0) begin
                if (falls >= 1 && falls <= 2) begin
                    checks++;
                    if (cyc - last_fall != 1600) begin
                        errors++;
                        $display("FAIL hsync_period got %0d want 1600", cyc - last_fall);
                    end
                end
                falls++;
                last_fall = cyc;
            end
            if (hs0 === 1'b0) begin
                low_cnt++;
            end else if (low_cnt != 0) begin
                checks++;
                if (low_cnt != 192) begin
                    errors++;
                    $display("FAIL hsync_width got %0d want 192", low_cnt);
                end
                low_cnt = 0;
            end
            prev = hs0;
        end
    end

    // Stimulus: initial reset, a mid-line reset on the default raster, random resets elsewhere.
    initial begin
        int unsigned rcnt [3];
        rcnt  = '{0, 0, 0};
        rst_n = '{1'b0, 1'b0, 1'b0};
        repeat (5) @(negedge clk);
        rst_n = '{1'b1, 1'b1, 1'b1};
        for (int cyc = 0; cyc < 20000; cyc++) begin
            @(negedge clk);
            rst_n[0] = (cyc != 6000);
            for (int i = 1; i < 3; i++) begin
                if (rcnt[i] > 0) begin
                    rcnt[i]  = rcnt[i] - 1;
                    rst_n[i] = 1'b0;
                end else begin
                    rst_n[i] = 1'b1;
                    if ($urandom_range(0, 1499) == 0) rcnt[i] = $urandom_range(1, 4);
                end
            end
        end
        repeat (2) @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
